// File: rtl/register_file_scoreboard.sv
// Register file (32 x 32-bit, r0 hardwired to zero) with an integrated
// per-register in-flight write scoreboard used by ID to detect RAW hazards.
// Writebacks may be bypassed to the read ports in the same cycle.
module register_file_scoreboard #(
    parameter int WRITE_BYPASS  = 1,
    parameter int MAX_IN_FLIGHT = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [37:0] wb_to_rf_bus,
    input  logic [4:0]  read_address_1,
    output logic [31:0] read_data_1,
    input  logic [4:0]  read_address_2,
    output logic [31:0] read_data_2,
    input  logic        issue_valid,
    input  logic [4:0]  issue_destination,
    output logic        read_1_pending,
    output logic        read_2_pending,
    output logic        scoreboard_error
);

    typedef struct packed {
        logic        write_enabled;
        logic [4:0]  write_address;
        logic [31:0] write_data;
    } wb_to_rf_t;

    localparam logic [1:0] max_count = 2'(MAX_IN_FLIGHT);
    localparam bit bypass_on = (WRITE_BYPASS != 0);

    wb_to_rf_t   wb;
    logic        retire;
    logic [31:0] regs_reg [0:31];
    logic [1:0]  count_all [0:31];
    logic [31:0] count_fault;
    logic        error_reg;

    assign wb     = wb_to_rf_bus;
    // A writeback to r0 is neither stored nor counted as a retire.
    assign retire = wb.write_enabled && (wb.write_address != 5'd0);

    // Register storage; r0 is never written so it keeps its reset value of 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= 32'd0;
            end
        end else if (retire) begin
            regs_reg[wb.write_address] <= wb.write_data;
        end
    end

    // One saturating in-flight counter per architectural register.
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        if (gi == 0) begin : g_zero
            assign count_all[gi]   = 2'd0;
            assign count_fault[gi] = 1'b0;
        end else begin : g_count
            logic       inc;
            logic       dec;
            logic [1:0] count_reg;
            logic [1:0] count_next;
            logic       fault;

            assign inc = issue_valid && (issue_destination == 5'(gi));
            assign dec = retire && (wb.write_address == 5'(gi));

            // Issue and retire to the same register cancel; otherwise
            // saturate at both ends and flag the illegal move.
            always_comb begin
                count_next = count_reg;
                fault      = 1'b0;
                if (inc && !dec) begin
                    if (count_reg >= max_count) begin
                        fault = 1'b1;
                    end else begin
                        count_next = count_reg + 2'd1;
                    end
                end else if (dec && !inc) begin
                    if (count_reg == 2'd0) begin
                        fault = 1'b1;
                    end else begin
                        count_next = count_reg - 2'd1;
                    end
                end
            end

            // Counter state update.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= 2'd0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign count_all[gi]   = count_reg;
            assign count_fault[gi] = fault;
        end
    end

    // Sticky error: once any counter over/underflows it stays set until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error_reg <= 1'b0;
        end else if (|count_fault) begin
            error_reg <= 1'b1;
        end
    end

    // Read port 1: storage or same-cycle writeback, forced to 0 during reset.
    always_comb begin
        read_data_1    = 32'd0;
        read_1_pending = 1'b0;
        if (reset_n && (read_address_1 != 5'd0)) begin
            if (bypass_on && retire && (wb.write_address == read_address_1)) begin
                read_data_1    = wb.write_data;
                read_1_pending = (count_all[read_address_1] > 2'd1);
            end else begin
                read_data_1    = regs_reg[read_address_1];
                read_1_pending = (count_all[read_address_1] != 2'd0);
            end
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        read_data_2    = 32'd0;
        read_2_pending = 1'b0;
        if (reset_n && (read_address_2 != 5'd0)) begin
            if (bypass_on && retire && (wb.write_address == read_address_2)) begin
                read_data_2    = wb.write_data;
                read_2_pending = (count_all[read_address_2] > 2'd1);
            end else begin
                read_data_2    = regs_reg[read_address_2];
                read_2_pending = (count_all[read_address_2] != 2'd0);
            end
        end
    end

    assign scoreboard_error = reset_n && error_reg;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomized self-checking bench for register_file_scoreboard, compared
// against a behavioural model of register contents and outstanding writes.
module tb_register_file_scoreboard;

    localparam int BYPASS = 1;
    localparam int MAXF   = 3;

    logic        clock;
    logic        reset_n;
    logic [37:0] wb_to_rf_bus;
    logic [4:0]  read_address_1;
    logic [31:0] read_data_1;
    logic [4:0]  read_address_2;
    logic [31:0] read_data_2;
    logic        issue_valid;
    logic [4:0]  issue_destination;
    logic        read_1_pending;
    logic        read_2_pending;
    logic        scoreboard_error;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    int          m_outstanding [32];
    logic        m_error;

    register_file_scoreboard #(
        .WRITE_BYPASS (BYPASS),
        .MAX_IN_FLIGHT(MAXF)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .wb_to_rf_bus     (wb_to_rf_bus),
        .read_address_1   (read_address_1),
        .read_data_1      (read_data_1),
        .read_address_2   (read_address_2),
        .read_data_2      (read_data_2),
        .issue_valid      (issue_valid),
        .issue_destination(issue_destination),
        .read_1_pending   (read_1_pending),
        .read_2_pending   (read_2_pending),
        .scoreboard_error (scoreboard_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i]        = 32'd0;
            m_outstanding[i] = 0;
        end
        m_error = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (BYPASS != 0 && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a, input logic we, input logic [4:0] wa);
        int remaining;
        if (a == 0) return 1'b0;
        remaining = m_outstanding[a];
        // A retiring write whose value is forwarded no longer blocks the reader.
        if (BYPASS != 0 && we && wa == a) remaining = remaining - 1;
        return remaining > 0;
    endfunction

    // One transaction: drive after the falling edge, check before the rising edge,
    // then advance the model to what the rising edge should produce.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic iv, input logic [4:0] id);
        logic iss, ret;
        @(negedge clock);
        wb_to_rf_bus      = {we, wa, wd};
        read_address_1    = a1;
        read_address_2    = a2;
        issue_valid       = iv;
        issue_destination = id;
        #1;
        $display("txn we=%0d wa=%0d wd=%h ra1=%0d rd1=%h p1=%0d ra2=%0d rd2=%h p2=%0d iv=%0d id=%0d err=%0d",
                 we, wa, wd, a1, read_data_1, read_1_pending, a2, read_data_2,
                 read_2_pending, iv, id, scoreboard_error);
        check_val("read_data_1", read_data_1, exp_data(a1, we, wa, wd));
        check_val("read_data_2", read_data_2, exp_data(a2, we, wa, wd));
        check_val("read_1_pending", 32'(read_1_pending), 32'(exp_pend(a1, we, wa)));
        check_val("read_2_pending", 32'(read_2_pending), 32'(exp_pend(a2, we, wa)));
        check_val("scoreboard_error", 32'(scoreboard_error), 32'(m_error));
        iss = iv && id != 0;
        ret = we && wa != 0;
        if (ret) m_regs[wa] = wd;
        if (!(iss && ret && id == wa)) begin
            if (iss) begin
                if (m_outstanding[id] == MAXF) m_error = 1'b1;
                else m_outstanding[id]++;
            end
            if (ret) begin
                if (m_outstanding[wa] == 0) m_error = 1'b1;
                else m_outstanding[wa]--;
            end
        end
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
        step(1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0);
    endtask

    // Assert reset just after a falling edge and check outputs go to 0 at once.
    task automatic do_reset(input logic [4:0] a1);
        @(negedge clock);
        read_address_1 = a1;
        read_address_2 = a1;
        wb_to_rf_bus   = {1'b1, a1, 32'hDEADBEEF};
        reset_n        = 1'b0;
        #1;
        $display("txn reset ra=%0d rd1=%h p1=%0d err=%0d", a1, read_data_1, read_1_pending, scoreboard_error);
        check_val("reset_read_data_1", read_data_1, 32'd0);
        check_val("reset_read_data_2", read_data_2, 32'd0);
        check_val("reset_pending_1", 32'(read_1_pending), 32'd0);
        check_val("reset_pending_2", 32'(read_2_pending), 32'd0);
        check_val("reset_error", 32'(scoreboard_error), 32'd0);
        model_clear();
        @(negedge clock);
        wb_to_rf_bus = '0;
        reset_n      = 1'b1;
    endtask

    initial begin
        logic [4:0]  wa, id, a1, a2;
        logic [31:0] wd;
        logic        we, iv;
        wb_to_rf_bus      = '0;
        read_address_1    = 5'd0;
        read_address_2    = 5'd0;
        issue_valid       = 1'b0;
        issue_destination = 5'd0;
        reset_n           = 1'b0;
        model_clear();
        do_reset(5'd1);

        // Basic write / read, r0 reads zero
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 5'd5);
        step(1'b1, 5'd5, 32'h12345678, 5'd1, 5'd0, 1'b0, 5'd0);
        idle_read(5'd5, 5'd0);
        // r0 writes and issues are ignored
        step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
        idle_read(5'd0, 5'd0);
        // Issue r7, see it pending, then retire with bypass
        step(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7);
        idle_read(5'd7, 5'd7);
        step(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 5'd0);
        idle_read(5'd7, 5'd7);
        // Same-cycle issue and retire on r9 leaves count at 1
        step(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, 5'd9);
        step(1'b1, 5'd9, 32'h00000099, 5'd9, 5'd9, 1'b1, 5'd9);
        idle_read(5'd9, 5'd9);
        step(1'b1, 5'd9, 32'h00000999, 5'd9, 5'd0, 1'b0, 5'd0);
        idle_read(5'd9, 5'd0);

        // Randomized legal traffic: never over-issue or retire an idle register
        for (int n = 0; n < 400; n++) begin
            id = 5'($urandom_range(0, 31));
            iv = ($urandom_range(0, 2) != 0) && (m_outstanding[id] < MAXF);
            wa = 5'($urandom_range(0, 31));
            we = ($urandom_range(0, 1) != 0) && (wa == 0 || m_outstanding[wa] > 0);
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? id : 5'($urandom_range(0, 31));
            step(we, wa, wd, a1, a2, iv, id);
        end

        // Drain, then overflow / underflow on r3
        do_reset(5'd2);
        for (int k = 0; k < 4; k++) step(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 5'd3);
        idle_read(5'd3, 5'd3);
        for (int k = 0; k < 3; k++) step(1'b1, 5'd3, 32'(k + 16), 5'd3, 5'd0, 1'b0, 5'd0);
        idle_read(5'd3, 5'd3);
        step(1'b1, 5'd3, 32'h33, 5'd3, 5'd0, 1'b0, 5'd0);
        idle_read(5'd3, 5'd3);

        // Mid-operation reset clears data, tracking and error
        step(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b1, 5'd4);
        step(1'b1, 5'd4, 32'h55, 5'd4, 5'd0, 1'b1, 5'd4);
        idle_read(5'd4, 5'd4);
        do_reset(5'd4);
        idle_read(5'd4, 5'd4);
        step(1'b1, 5'd4, 32'h77, 5'd4, 5'd0, 1'b0, 5'd0);
        idle_read(5'd4, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 SHALL have parameter WRITE_BYPASS, default 1: when 1, a same-cycle writeback is forwarded to the read ports.
REQ-002 SHALL have parameter MAX_IN_FLIGHT, default 3: maximum outstanding writes tracked per register (range 1..3).
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port wb_to_rf_bus, input, 38 (WBToRegisterFileData: write_enabled, write_address[4:0], write_data[31:0]): writeback request from WB.
REQ-006 SHALL have port read_address_1, input, 5: ID source register 1 index.
REQ-007 SHALL have port read_data_1, output, 32: value of register read_address_1.
REQ-008 SHALL have port read_address_2, input, 5: ID source register 2 index.
REQ-009 SHALL have port read_data_2, output, 32: value of register read_address_2.
REQ-010 SHALL have port issue_valid, input, 1: ID issues an instruction that will write issue_destination.
REQ-011 SHALL have port issue_destination, input, 5: destination of the issued instruction.
REQ-012 SHALL have port read_1_pending, output, 1: read_address_1 has an outstanding write; ID must stall.
REQ-013 SHALL have port read_2_pending, output, 1: as REQ-012 for read_address_2.
REQ-014 SHALL have port scoreboard_error, output, 1: sticky flag for counter overflow or underflow.

Function
REQ-015 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-016 SHALL write write_data to write_address at the rising edge when write_enabled=1 and write_address!=0.
REQ-017 SHALL produce read data combinationally (zero latency) from storage.
REQ-018 SHALL, when WRITE_BYPASS=1, write_enabled=1 and write_address==read_address!=0, drive read_data=write_data in the same cycle.
REQ-019 SHALL keep a 2-bit in-flight counter per register 1..31; register 0 is never pending.
REQ-020 SHALL increment counter[issue_destination] when issue_valid=1 and issue_destination!=0.
REQ-021 SHALL decrement counter[write_address] when write_enabled=1 and write_address!=0.
REQ-022 SHALL leave the counter unchanged when an issue and a retire hit the same register in the same cycle.
REQ-023 SHALL, on an increment at MAX_IN_FLIGHT, leave the counter unchanged and set scoreboard_error.
REQ-024 SHALL, on a decrement at 0, leave the counter unchanged and set scoreboard_error.
REQ-025 SHALL drive read_N_pending=1 iff read_address_N!=0 and the registered counter is nonzero.
REQ-026 SHALL, when WRITE_BYPASS=1 and the counter is 1 with a retire to that register this cycle, drive read_N_pending=0 (data bypassed).
REQ-027 SHALL NOT let a same-cycle issue affect pending outputs before the next cycle.
REQ-028 SHALL keep scoreboard_error at 1 until reset.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously clear all registers, counters and scoreboard_error to 0.
REQ-030 SHALL, during reset, drive read_data_1/2=0, read_1/2_pending=0 and scoreboard_error=0, with no bypass.
REQ-031 SHALL abandon any in-flight tracking on a reset asserted mid-operation; the first cycle after release SHALL behave as post-reset.

Verification
REQ-032 Write r5=0x12345678; next cycle read_address_1=5 -> read_data_1=0x12345678; read_address_2=0 -> read_data_2=0.
REQ-033 Write r0=0xFFFFFFFF, then issue r0 -> read r0=0, pending=0, counter unchanged, error=0.
REQ-034 Issue r7; next cycle read r7 -> pending=1; WB write r7=0xA5A5A5A5 same cycle -> pending=0, read_data=0xA5A5A5A5 (bypass).
REQ-035 Issue r3 three times, then a fourth -> error=1, counter=3; three retires -> pending=0; a further retire -> error stays 1.
REQ-036 Counter r9=1; issue and retire r9 in the same cycle -> next cycle counter=1, pending=1.
REQ-037 Write r4=0x55, issue r4, assert reset_n=0 mid-cycle -> immediately read r4=0, pending=0, error=0.
